// File: rtl/led_pattern_pkg.sv
// Shared definitions for the LED pattern engine: mode encodings,
// direction encoding and the per-mode initial pattern helper.
package led_pattern_pkg;

    // Pattern select encodings carried on the mode input.
    localparam logic [1:0] MODE_CHASE_L  = 2'd0;
    localparam logic [1:0] MODE_CHASE_R  = 2'd1;
    localparam logic [1:0] MODE_FILL     = 2'd2;
    localparam logic [1:0] MODE_PINGPONG = 2'd3;

    // Direction flag encoding used by PINGPONG.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Widest supported LED bar; the helper returns this many bits and
    // callers narrow the result to their own width.
    localparam int unsigned MAX_LEDS = 32;

    // Initial pattern shown right after entering a mode.
    function automatic logic [MAX_LEDS-1:0] init_pattern(
        input logic [1:0]  mode,
        input int unsigned width
    );
        logic [MAX_LEDS-1:0] p;
        p = '0;
        case (mode)
            MODE_CHASE_R: p = MAX_LEDS'(1) << (width - 1);
            MODE_FILL:    p = '0;
            default:      p = MAX_LEDS'(1);
        endcase
        return p;
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Divides the accepted step-enable pulses by DIV.
// Ports: clk, reset (async, active-high), clear (sync restart),
//        en (accepted tick), out_tick (high with the DIV-th accepted tick).
module tick_divider
    import led_pattern_pkg::*;
#(
    parameter int unsigned DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic out_tick
);

    localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] count;
    logic         wrap;

    assign wrap = (count == LAST);

    // Combinational so the engine advances at the same edge that
    // clears the counter; clear always wins.
    assign out_tick = en && !clear && wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            if (wrap) begin
                count <= '0;
            end else begin
                count <= count + W'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// LED pattern engine: one shared pattern register stepped by a divided
// tick, with CHASE_L, CHASE_R, FILL and PINGPONG patterns.
// Ports: clk, reset (async, active-high), tick (step enable pulse),
//        pause (freeze level), mode[1:0] (pattern select),
//        leds[N_LEDS-1:0] (registered pattern), step (one-cycle advance flag).
module led_pattern_engine
    import led_pattern_pkg::*;
#(
    parameter int unsigned N_LEDS   = 8,
    parameter int unsigned STEP_DIV = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              pause,
    input  logic [1:0]        mode,
    output logic [N_LEDS-1:0] leds,
    output logic              step
);

    if (N_LEDS < 2 || N_LEDS > MAX_LEDS) begin : g_bad_leds
        $error("N_LEDS out of range 2..32");
    end
    if (STEP_DIV < 1 || STEP_DIV > 255) begin : g_bad_div
        $error("STEP_DIV out of range 1..255");
    end

    localparam logic [N_LEDS-1:0] LEDS_BIT0 = {{(N_LEDS-1){1'b0}}, 1'b1};

    logic [1:0]        mode_q;
    logic              dir;
    logic              mode_chg;
    logic              div_en;
    logic              adv;
    logic [N_LEDS-1:0] init_leds;
    logic [N_LEDS-1:0] next_leds;
    logic              next_dir;

    // A mode change overrides both tick and pause.
    assign mode_chg = (mode != mode_q);
    assign div_en   = tick && !pause && !mode_chg;

    assign init_leds = N_LEDS'(init_pattern(mode, N_LEDS));

    tick_divider #(
        .DIV (STEP_DIV)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .clear    (mode_chg),
        .en       (div_en),
        .out_tick (adv)
    );

    // Next pattern for the currently registered mode.
    always_comb begin
        next_leds = leds;
        next_dir  = dir;
        unique case (mode_q)
            MODE_CHASE_L: begin
                next_leds = {leds[N_LEDS-2:0], leds[N_LEDS-1]};
            end
            MODE_CHASE_R: begin
                next_leds = {leds[0], leds[N_LEDS-1:1]};
            end
            MODE_FILL: begin
                // All ones wraps back to dark, giving N_LEDS+1 states.
                if (&leds) begin
                    next_leds = '0;
                end else begin
                    next_leds = {leds[N_LEDS-2:0], 1'b1};
                end
            end
            MODE_PINGPONG: begin
                // Flip direction on the step that lands on an endpoint,
                // so each endpoint is shown once per pass.
                if (dir == DIR_UP) begin
                    next_leds = leds << 1;
                    if (leds[N_LEDS-2]) begin
                        next_dir = DIR_DOWN;
                    end
                end else begin
                    next_leds = leds >> 1;
                    if (leds[1]) begin
                        next_dir = DIR_UP;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= MODE_CHASE_L;
            leds   <= LEDS_BIT0;
            dir    <= DIR_UP;
            step   <= 1'b0;
        end else if (mode_chg) begin
            mode_q <= mode;
            leds   <= init_leds;
            dir    <= DIR_UP;
            step   <= 1'b0;
        end else if (adv) begin
            leds   <= next_leds;
            dir    <= next_dir;
            step   <= 1'b1;
        end else begin
            step   <= 1'b0;
        end
    end

endmodule
